// File: rtl/cmp_pkg.sv
// Shared types and helpers for the lane-wise stream comparator.
// lane_cmp works on zero-extended lanes of up to 64 bits; w gives the real lane width.
package cmp_pkg;

    typedef enum logic [2:0] {
        CMP_EQ = 3'd0,
        CMP_NE = 3'd1,
        CMP_LT = 3'd2,
        CMP_LE = 3'd3,
        CMP_GT = 3'd4,
        CMP_GE = 3'd5
    } cmp_op_t;

    localparam int CMP_MAX_LANE_W = 64;

    function automatic bit lanes_ok(input int w_data, input int lanes);
        return (lanes > 0) && (w_data % lanes == 0) && (w_data / lanes <= CMP_MAX_LANE_W);
    endfunction

    function automatic logic lane_cmp(
        input logic [63:0] a,
        input logic [63:0] b,
        input cmp_op_t     op,
        input logic        sgn,
        input int unsigned w
    );
        logic [64:0] ea;
        logic [64:0] eb;
        logic [64:0] ext;
        logic        res;
        // Extend both lanes to 65 bits so one signed compare covers both modes.
        ext = {65{1'b1}} << w;
        ea  = {1'b0, a};
        eb  = {1'b0, b};
        if (sgn && (|(a & (64'd1 << (w - 1))))) ea = ea | ext;
        if (sgn && (|(b & (64'd1 << (w - 1))))) eb = eb | ext;
        case (op)
            CMP_EQ:  res = (ea == eb);
            CMP_NE:  res = (ea != eb);
            CMP_LT:  res = ($signed(ea) <  $signed(eb));
            CMP_LE:  res = ($signed(ea) <= $signed(eb));
            CMP_GT:  res = ($signed(ea) >  $signed(eb));
            CMP_GE:  res = ($signed(ea) >= $signed(eb));
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dti.sv
// Data/valid/ready stream bundle; a transfer happens on valid & ready.
interface dti #(
    parameter int W = 16
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input  ready);
    modport consumer (input  data, input  valid, output ready);
endinterface

// File: rtl/dti_reg.sv
// One-deep registered stage between two dti streams, generic in width.
// Latency: 1 cycle from src handshake to dst.valid.
// Backpressure: accepts while empty or draining, so full throughput; src.ready is 0 in reset.
module dti_reg (
    input  logic clk,
    input  logic rst,
    dti.consumer src,
    dti.producer dst
);

    assign src.ready = ~rst & (~dst.valid | dst.ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            dst.valid <= 1'b0;
            dst.data  <= '0;
        end else if (src.valid & src.ready) begin
            dst.data  <= src.data;
            dst.valid <= 1'b1;
        end else if (dst.ready) begin
            dst.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cmp_pipe.sv
// Joins din0/din1, compares LANES lanes with a fixed operator; CMP_PIPE_STATS_EN adds hit_cnt.
// Latency: 1 cycle from the joint input handshake to dout.valid.
// Backpressure: both inputs consumed together only when the output register can load.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int W_DATA = 16,
    parameter int LANES  = 1,
    parameter int OP     = 1,
    parameter int SIGNED = 0
) (
    input  logic        clk,
    input  logic        rst,
    dti.consumer        din0,
    dti.consumer        din1,
    dti.producer        dout
`ifdef CMP_PIPE_STATS_EN
    ,
    output logic [31:0] hit_cnt
`endif
);

    localparam int      LW   = W_DATA / LANES;
    localparam cmp_op_t OP_E = cmp_op_t'(OP[2:0]);

    generate
        if (!lanes_ok(W_DATA, LANES)) begin : g_bad_lanes
            $error("cmp_pipe: W_DATA must split into LANES lanes of at most 64 bits");
        end
        if (OP < 0 || OP > 5) begin : g_bad_op
            $error("cmp_pipe: OP must be in 0..5");
        end
    endgenerate

    dti #(.W(LANES)) res_s ();

    logic [LANES-1:0] result;

    always_comb begin
        result = '0;
        for (int i = 0; i < LANES; i++) begin
            result[i] = lane_cmp(64'(din0.data[i*LW +: LW]), 64'(din1.data[i*LW +: LW]),
                                 OP_E, SIGNED != 0, LW);
        end
    end

    assign res_s.data  = result;
    assign res_s.valid = din0.valid & din1.valid;

    // Same ready to both sides so the pair is never split.
    assign din0.ready  = res_s.valid & res_s.ready;
    assign din1.ready  = res_s.valid & res_s.ready;

    dti_reg u_out (
        .clk (clk),
        .rst (rst),
        .src (res_s),
        .dst (dout)
    );

`ifdef CMP_PIPE_STATS_EN
    logic [31:0] hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= '0;
        end else if (dout.valid & dout.ready & (|dout.data) & (hit_q != 32'hFFFF_FFFF)) begin
            hit_q <= hit_q + 32'd1;
        end
    end

    assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed and randomised-backpressure checks across several cmp_pipe configurations.
module tb_cmp_pipe;

    localparam int N = 7;
    localparam int OPS [N] = '{0, 1, 2, 2, 3, 4, 5};
    localparam int LAN [N] = '{1, 1, 4, 4, 2, 16, 4};
    localparam int SGN [N] = '{0, 0, 1, 0, 0, 1, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d0, d1;
    logic        v0, v1, r;

    logic [15:0] res  [N];
    logic        vld  [N];
    logic        rdy0 [N];
    logic        rdy1 [N];
`ifdef CMP_PIPE_STATS_EN
    logic [31:0] hc   [N];
`endif

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            dti #(.W(16))     i0 ();
            dti #(.W(16))     i1 ();
            dti #(.W(LAN[g])) o  ();

            assign i0.data  = d0;
            assign i0.valid = v0;
            assign i1.data  = d1;
            assign i1.valid = v1;
            assign o.ready  = r;

            cmp_pipe #(
                .W_DATA (16),
                .LANES  (LAN[g]),
                .OP     (OPS[g]),
                .SIGNED (SGN[g])
            ) u_dut (
                .clk     (clk),
                .rst     (rst),
                .din0    (i0),
                .din1    (i1),
                .dout    (o)
`ifdef CMP_PIPE_STATS_EN
                ,
                .hit_cnt (hc[g])
`endif
            );

            assign res[g]  = 16'(o.data);
            assign vld[g]  = o.valid;
            assign rdy0[g] = i0.ready;
            assign rdy1[g] = i1.ready;
        end
    endgenerate

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: lanes rebuilt bit by bit into integers.
    function automatic logic [15:0] model(input int op, input int sg, input int lanes,
                                          input logic [15:0] a, input logic [15:0] b);
        int          lw;
        longint      x, y;
        logic [15:0] out;
        lw  = 16 / lanes;
        out = '0;
        for (int i = 0; i < lanes; i++) begin
            x = 0;
            y = 0;
            for (int k = 0; k < lw; k++) begin
                x = x | (longint'(a[i*lw+k]) << k);
                y = y | (longint'(b[i*lw+k]) << k);
            end
            if (sg != 0 && a[i*lw+lw-1]) x = x - (longint'(1) << lw);
            if (sg != 0 && b[i*lw+lw-1]) y = y - (longint'(1) << lw);
            case (op)
                0: out[i] = (x == y);
                1: out[i] = (x != y);
                2: out[i] = (x <  y);
                3: out[i] = (x <= y);
                4: out[i] = (x >  y);
                default: out[i] = (x >= y);
            endcase
        end
        return out;
    endfunction

    logic [15:0] vec_a [5] = '{16'h0005, 16'h0005, 16'hFFFF, 16'hF123, 16'h0000};
    logic [15:0] vec_b [5] = '{16'h0005, 16'h0006, 16'h0000, 16'h1023, 16'hFFFF};
    // Per row: eq, ne, lt signed x4, lt unsigned x4, le unsigned x2, gt signed x16, ge signed x4.
    logic [15:0] vexp [5][N] = '{
        '{16'h1, 16'h0, 16'h0, 16'h0, 16'h3, 16'h0000, 16'hF},
        '{16'h0, 16'h1, 16'h1, 16'h1, 16'h3, 16'h0002, 16'hE},
        '{16'h0, 16'h1, 16'hF, 16'h0, 16'h0, 16'h0000, 16'h0},
        '{16'h0, 16'h1, 16'h8, 16'h0, 16'h1, 16'h0000, 16'h7},
        '{16'h0, 16'h1, 16'h0, 16'hF, 16'h3, 16'hFFFF, 16'hF}
    };

    logic [31:0] sb [$];
    logic [31:0] pair;
    logic [15:0] held [N];
    int          sent, recv, cyc;
    logic        st, hs;

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; r = 1'b0; d0 = '0; d1 = '0;
        tick();
        v0 = 1'b1; v1 = 1'b1; r = 1'b1;
        #2;
        for (int g = 0; g < N; g++) check("rst_rdy", {31'd0, rdy0[g]}, 32'd0);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        for (int g = 0; g < N; g++) begin
            check("rst_vld", {31'd0, vld[g]}, 32'd0);
            check("rst_dat", {16'd0, res[g]}, 32'd0);
        end

        // Reset while a result is stalled at the output.
        rst = 1'b0; r = 1'b0; d0 = 16'd5; d1 = 16'd6; v0 = 1'b1; v1 = 1'b1;
        #2;
        check("stall_hs_rdy", {31'd0, rdy0[1]}, 32'd1);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        #2;
        check("stall_vld", {31'd0, vld[1]}, 32'd1);
        check("stall_dat", {16'd0, res[1]}, 32'd1);
        tick();
        d0 = 16'd7; d1 = 16'd7; v0 = 1'b1; v1 = 1'b1;
        #2;
        check("stall_hold", {31'd0, vld[1]}, 32'd1);
        check("stall_rdy0", {31'd0, rdy0[1]}, 32'd0);
        check("stall_rdy1", {31'd0, rdy1[1]}, 32'd0);
        v0 = 1'b0; v1 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        for (int g = 0; g < N; g++) begin
            check("midrst_vld", {31'd0, vld[g]}, 32'd0);
            check("midrst_dat", {16'd0, res[g]}, 32'd0);
        end
        r = 1'b1;
        tick();
        check("midrst_gone", {31'd0, vld[1]}, 32'd0);

        // Back-to-back directed vectors, one result per cycle.
        for (int i = 0; i < 5; i++) begin
            d0 = vec_a[i]; d1 = vec_b[i]; v0 = 1'b1; v1 = 1'b1;
            #2;
            check("strm_rdy", {31'd0, rdy0[1]}, 32'd1);
            tick();
            for (int g = 0; g < N; g++) begin
                check($sformatf("strm_vld_%0d_%0d", i, g), {31'd0, vld[g]}, 32'd1);
                check($sformatf("strm_dat_%0d_%0d", i, g), {16'd0, res[g]}, {16'd0, vexp[i][g]});
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
        check("strm_drain", {31'd0, vld[1]}, 32'd0);

        // One side valid only.
        d0 = 16'd9; d1 = 16'd9; v0 = 1'b1; v1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("unbal_rdy0", {31'd0, rdy0[0]}, 32'd0);
            check("unbal_rdy1", {31'd0, rdy1[0]}, 32'd0);
            tick();
            check("unbal_vld", {31'd0, vld[0]}, 32'd0);
        end
        v1 = 1'b1;
        #2;
        check("unbal_join_rdy", {31'd0, rdy0[0]}, 32'd1);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        check("unbal_join_vld", {31'd0, vld[0]}, 32'd1);
        check("unbal_join_dat", {16'd0, res[0]}, 32'd1);
        tick();

        // Random pairs under random backpressure against the reference model.
        sent = 0; recv = 0; cyc = 0;
        while (recv < 200 && cyc < 5000) begin
            cyc++;
            r = 1'($urandom_range(0, 1));
            if (!v0 && sent < 200 && $urandom_range(0, 3) != 0) begin
                d0 = 16'($urandom);
                d1 = 16'($urandom);
                if ($urandom_range(0, 3) == 0) d1 = d0;
                v0 = 1'b1; v1 = 1'b1;
            end
            #3;
            check("rnd_rdy0", {31'd0, rdy0[0]}, {31'd0, v0 & v1 & (~vld[0] | r)});
            check("rnd_rdy1", {31'd0, rdy1[0]}, {31'd0, v0 & v1 & (~vld[0] | r)});
            if (vld[0] && r) begin
                if (sb.size() == 0) begin
                    check("rnd_spurious", 32'd1, 32'd0);
                end else begin
                    pair = sb.pop_front();
                    for (int g = 0; g < N; g++) begin
                        check("rnd_vld", {31'd0, vld[g]}, 32'd1);
                        check($sformatf("rnd_dat_%0d", g), {16'd0, res[g]},
                              {16'd0, model(OPS[g], SGN[g], LAN[g], pair[31:16], pair[15:0])});
                    end
                end
                recv++;
            end
            st = vld[0] && !r;
            for (int g = 0; g < N; g++) held[g] = res[g];
            hs = v0 && rdy0[0];
            if (hs) begin
                sb.push_back({d0, d1});
                sent++;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                v0 = 1'b0; v1 = 1'b0;
            end
            if (st) begin
                for (int g = 0; g < N; g++) begin
                    check("rnd_stall_vld", {31'd0, vld[g]}, 32'd1);
                    check("rnd_stall_dat", {16'd0, res[g]}, {16'd0, held[g]});
                end
            end
        end
        if (recv < 200) check("rnd_timeout", recv, 32'd200);
        v0 = 1'b0; v1 = 1'b0;

`ifdef CMP_PIPE_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0; r = 1'b1;
        check("hit_rst", hc[0], 32'd0);
        for (int i = 0; i < 10; i++) begin
            d0 = 16'(i);
            d1 = (i % 3 == 0) ? 16'(i) : 16'(i + 1);
            v0 = 1'b1; v1 = 1'b1;
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
        tick();
        check("hit_count", hc[0], 32'd4);
        force tb_cmp_pipe.g_dut[0].u_dut.hit_q = 32'hFFFF_FFFE;
        #1;
        release tb_cmp_pipe.g_dut[0].u_dut.hit_q;
        for (int i = 0; i < 3; i++) begin
            d0 = 16'h00AA; d1 = 16'h00AA; v0 = 1'b1; v1 = 1'b1;
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
        tick();
        check("hit_sat", hc[0], 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cmp_pipe.md
Name: cmp_pipe

Overview:
- Parametrised, registered two-operand comparator on dti streams.
- Joins `din0` and `din1`, splits each operand into LANES equal lanes, and applies one compile-time relational operator per lane (signed or unsigned).
- Emits a LANES-bit result word through a one-deep output register with full-throughput valid/ready.
- Successor to the single-bit combinational eq/neq comparators; sits wherever a stream predicate feeds filter, mux or select logic.

Parameters:
- W_DATA, 16, operand width in bits; must be a multiple of LANES.
- LANES, 1, number of independent equal-width lanes; lane i = bits [(i+1)*W_DATA/LANES-1 : i*W_DATA/LANES].
- OP, 1, operator: 0 eq, 1 ne, 2 lt, 3 le, 4 gt, 5 ge; any other value is an elaboration error.
- SIGNED, 0, 1 = lanes compared as two's complement, 0 = unsigned.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- din0  dti.consumer  W_DATA  left operand stream (data, valid, ready).
- din1  dti.consumer  W_DATA  right operand stream.
- dout  dti.producer  LANES  per-lane result; bit i = (din0 lane i OP din1 lane i).
- Interface decided: one clock `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- Join: a transaction exists when `din0.valid & din1.valid`.
- Ready: `din0.ready = din1.ready = din0.valid & din1.valid & load`, where `load = ~dout.valid | dout.ready`.
  - Both inputs are consumed in the same cycle or not at all.
  - Neither ready depends on its own valid alone.
- Output register:
  - On `load & both valid`: `dout.data <= result`, `dout.valid <= 1`.
  - Else on `dout.ready`: `dout.valid <= 0`.
  - Else hold.
- Latency: 1 cycle from input handshake to `dout.valid`.
- Throughput: 1 result per cycle when `dout.ready` is held high; a pop and a push in the same cycle are legal and keep valid = 1.
- Stall: while `dout.valid & ~dout.ready`, `dout.data` and `dout.valid` are stable and both input readies are 0.
- Reset: `dout.valid = 0`, `dout.data = 0`; a pending result is discarded. Input readies are 0 during the reset cycle.
- Arithmetic:
  - Per-lane compare at lane width.
  - SIGNED=1 uses the lane MSB as the sign bit; no cross-lane carry.
  - eq/ne ignore SIGNED.
- Boundaries:
  - LANES=1 reduces to a whole-word compare.
  - Lanes 1 bit wide with SIGNED=1 are legal: value 1 reads as -1.
  - One input valid without the other: no consume and no output change.

Optional Feature:
- Macro: CMP_PIPE_STATS_EN.
- Defined:
  - Adds port `hit_cnt  output  32` counting output handshakes whose `dout.data` is nonzero.
  - Saturates at 0xFFFF_FFFF; reset to 0.
  - Increments on the cycle `dout.valid & dout.ready & |dout.data`.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package `cmp_pkg`:
  - enum `cmp_op_t` (CMP_EQ=0 … CMP_GE=5).
  - function `lane_cmp(a, b, op, signed)`.
  - localparam check macro for W_DATA % LANES.
- Sub-module `dti_reg`: the one-deep valid/ready output register, generic in width. cmp_pipe instantiates it for `dout`.

Test Plan:
- Reset mid-stall: hold `dout.ready=0` with a result pending, assert rst 1 cycle -> next cycle `dout.valid=0`, `dout.data=0`; the pending result never appears.
- OP=1, W=16, LANES=1, stream (5,5), (5,6), (0xFFFF,0) with `dout.ready=1` -> dout 0, 1, 1 on consecutive cycles, each 1 cycle after its input handshake, no bubbles.
- OP=2, LANES=4, W=16, SIGNED=1: din0=0xF123, din1=0x1023 -> lanes (lsb first) 3<3=0, 2<2=0, 1<0=0, -1<1=1 -> dout=4'b1000. Same operands with SIGNED=0 -> 4'b0000.
- Backpressure: random `dout.ready` (≈50%), 200 random pairs -> scoreboard exact order/value match; `dout.data` stable whenever valid & ~ready; `din0.ready==din1.ready` every cycle.
- Unbalanced valids: `din0.valid=1` for 5 cycles, `din1.valid=0` -> both readies 0 and `dout.valid` unchanged; raise `din1.valid` -> handshake on that cycle.
- CMP_PIPE_STATS_EN: OP=0, send 10 pairs with 4 equal, `dout.ready=1` -> `hit_cnt=4`. Preload `hit_cnt` via force to 0xFFFF_FFFE, send 3 equal pairs -> `hit_cnt` stays 0xFFFF_FFFF.
